// File: rtl/pool_ot_serializer_pkg.sv
// Shared CNN-core defines plus the types used by the pooled-frame serializer.
// The defines are guarded so any other core file carrying the same header can coexist.
`ifndef DEFINES_CNN_CORE
`define DEFINES_CNN_CORE
`define CI     3
`define P_SIZE 4
`define OF_BW  32
`define POOL_K 2
`endif

package pool_ot_serializer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // Width of a counter that counts 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pool_idx_counter.sv
// Walks the flat pixel index of a pooled frame as nested channel/pixel counters,
// so the channel number and the last-of-channel/last-of-frame flags need no divider.
module pool_idx_counter
   import pool_ot_serializer_pkg::*;
#(
   parameter int CI     = `CI,
   parameter int P_SIZE = `P_SIZE,
   localparam int PP    = P_SIZE * P_SIZE,
   localparam int N_PIX = CI * PP,
   localparam int IDX_W = cnt_width(N_PIX),
   localparam int PIX_W = cnt_width(PP),
   localparam int CH_W  = cnt_width(CI)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clr,
   input  logic             i_adv,
   output logic [IDX_W-1:0] o_idx,
   output logic [CH_W-1:0]  o_ch,
   output logic             o_last_ch,
   output logic             o_last
);

   localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(PP - 1);
   localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(CI - 1);

   logic [IDX_W-1:0] r_idx;
   logic [PIX_W-1:0] r_pix;
   logic [CH_W-1:0]  r_ch;
   logic             w_last_ch;
   logic             w_last;

   assign w_last_ch = (r_pix == PIX_MAX);
   assign w_last    = w_last_ch && (r_ch == CH_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idx <= '0;
         r_pix <= '0;
         r_ch  <= '0;
      end else if (i_clr) begin
         r_idx <= '0;
         r_pix <= '0;
         r_ch  <= '0;
      end else if (i_adv) begin
         if (w_last) begin
            r_idx <= '0;
            r_pix <= '0;
            r_ch  <= '0;
         end else if (w_last_ch) begin
            r_idx <= r_idx + IDX_W'(1);
            r_pix <= '0;
            r_ch  <= r_ch + CH_W'(1);
         end else begin
            r_idx <= r_idx + IDX_W'(1);
            r_pix <= r_pix + PIX_W'(1);
         end
      end
   end

   assign o_idx     = r_idx;
   assign o_ch      = r_ch;
   assign o_last_ch = w_last_ch;
   assign o_last    = w_last;

endmodule

// File: rtl/pool_ot_serializer.sv
// Captures one pooled frame and streams it out pixel by pixel, channel-major.
// Handshake: a beat moves on a rising edge where o_ot_valid and i_ot_ready are both 1.
module pool_ot_serializer
   import pool_ot_serializer_pkg::*;
#(
   parameter int CI     = `CI,
   parameter int P_SIZE = `P_SIZE,
   parameter int OF_BW  = `OF_BW,
   localparam int N_PIX = CI * P_SIZE * P_SIZE,
   localparam int IDX_W = cnt_width(N_PIX),
   localparam int CH_W  = cnt_width(CI)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_in_valid,
   input  logic [N_PIX*OF_BW-1:0] i_in_fmap,
   output logic                   o_in_ready,
   output logic                   o_ot_valid,
   input  logic                   i_ot_ready,
   output logic [OF_BW-1:0]       o_ot_data,
   output logic [CH_W-1:0]        o_ot_ch,
   output logic                   o_ot_last_ch,
   output logic                   o_ot_last,
   output logic                   o_overrun,
   output state_t                 o_dbg_state
);

   state_t                 r_state;
   state_t                 w_state_next;
   logic [N_PIX*OF_BW-1:0] r_frame;
   logic                   r_overrun;
   logic                   w_clr;
   logic                   w_adv;
   logic [IDX_W-1:0]       w_idx;
   logic                   w_last_ch;
   logic                   w_last;

   pool_idx_counter #(
      .CI     (CI),
      .P_SIZE (P_SIZE)
   ) u_idx (
      .clk       (clk),
      .reset     (reset),
      .i_clr     (w_clr),
      .i_adv     (w_adv),
      .o_idx     (w_idx),
      .o_ch      (o_ot_ch),
      .o_last_ch (w_last_ch),
      .o_last    (w_last)
   );

   always_comb begin
      w_state_next = r_state;
      w_clr        = 1'b0;
      w_adv        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_in_valid) begin
               w_clr        = 1'b1;
               w_state_next = ST_SEND;
            end
         end
         ST_SEND: begin
            w_adv = i_ot_ready;
            if (i_ot_ready && w_last) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_frame   <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_clr) r_frame <= i_in_fmap;
         // A pulse while busy is dropped, including on the final beat's cycle.
         if (i_in_valid && (r_state == ST_SEND)) r_overrun <= 1'b1;
      end
   end

   assign o_in_ready   = (r_state == ST_IDLE) && !reset;
   assign o_ot_valid   = (r_state == ST_SEND);
   assign o_ot_data    = r_frame[int'(w_idx)*OF_BW +: OF_BW];
   assign o_ot_last_ch = o_ot_valid && w_last_ch;
   assign o_ot_last    = o_ot_valid && w_last;
   assign o_overrun    = r_overrun;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_pool_ot_serializer.sv
// Directed sequence of pooled frames with random data and ready patterns,
// compared beat by beat against an index-arithmetic model of the output stream.
module tb_pool_ot_serializer;
   import pool_ot_serializer_pkg::*;

   localparam int CI     = 3;
   localparam int P_SIZE = 4;
   localparam int OF_BW  = 32;
   localparam int PP     = P_SIZE * P_SIZE;
   localparam int N_PIX  = CI * PP;
   localparam int CH_W   = 2;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   i_in_valid;
   logic [N_PIX*OF_BW-1:0] i_in_fmap;
   logic                   o_in_ready;
   logic                   o_ot_valid;
   logic                   i_ot_ready;
   logic [OF_BW-1:0]       o_ot_data;
   logic [CH_W-1:0]        o_ot_ch;
   logic                   o_ot_last_ch;
   logic                   o_ot_last;
   logic                   o_overrun;
   state_t                 dbg_state;

   int checks   = 0;
   int failures = 0;
   logic [OF_BW-1:0] frame_q [N_PIX];

   always #5 clk = ~clk;

   pool_ot_serializer #(
      .CI     (CI),
      .P_SIZE (P_SIZE),
      .OF_BW  (OF_BW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i_in_valid   (i_in_valid),
      .i_in_fmap    (i_in_fmap),
      .o_in_ready   (o_in_ready),
      .o_ot_valid   (o_ot_valid),
      .i_ot_ready   (i_ot_ready),
      .o_ot_data    (o_ot_data),
      .o_ot_ch      (o_ot_ch),
      .o_ot_last_ch (o_ot_last_ch),
      .o_ot_last    (o_ot_last),
      .o_overrun    (o_overrun),
      .o_dbg_state  (dbg_state)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // 0: k+100, 1: k, 2: 1000+k, 3: random
   task automatic load_frame(input int mode);
      for (int k = 0; k < N_PIX; k++) begin
         case (mode)
            0:       frame_q[k] = OF_BW'(k + 100);
            1:       frame_q[k] = OF_BW'(k);
            2:       frame_q[k] = OF_BW'(1000 + k);
            default: frame_q[k] = $urandom;
         endcase
      end
   endtask

   task automatic send_frame();
      for (int k = 0; k < N_PIX; k++) i_in_fmap[k*OF_BW +: OF_BW] = frame_q[k];
      i_in_valid = 1'b1;
      @(negedge clk);
      i_in_valid = 1'b0;
   endtask

   // ready_mode 0: always, 1: stall 5 cycles at beat 7, 2: random.
   task automatic recv_frame(input int ready_mode, input int ovr_at, input int abort_at);
      int  k     = 0;
      int  cyc   = 0;
      int  stall = 0;
      bit  r;
      while (k < N_PIX && k != abort_at && cyc < 400) begin
         case (ready_mode)
            0:       r = 1'b1;
            1:       r = !(k == 7 && stall < 5);
            default: r = ($urandom_range(0, 3) != 0);
         endcase
         if (ready_mode == 1 && k == 7 && stall < 5) stall++;
         i_ot_ready = r;
         i_in_valid = (cyc == ovr_at);
         if (cyc == ovr_at) i_in_fmap = {N_PIX{32'($urandom)}};
         check("beat_valid", o_ot_valid, 1);
         check("busy_ready", o_in_ready, 0);
         check("beat_data", o_ot_data, frame_q[k]);
         check("beat_ch", o_ot_ch, k / PP);
         check("beat_last_ch", o_ot_last_ch, (k % PP) == PP - 1);
         check("beat_last", o_ot_last, k == N_PIX - 1);
         if (r) k++;
         @(negedge clk);
         cyc++;
      end
      i_ot_ready = 1'b0;
      i_in_valid = 1'b0;
      if (abort_at < 0) begin
         check("beat_count", k, N_PIX);
         check("idle_ready", o_in_ready, 1);
         check("idle_valid", o_ot_valid, 0);
      end else begin
         check("abort_beat", k, abort_at);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, o_ot_valid, 0);
      check({tag, "_data"}, o_ot_data, 0);
      check({tag, "_ch"}, o_ot_ch, 0);
      check({tag, "_last_ch"}, o_ot_last_ch, 0);
      check({tag, "_last"}, o_ot_last, 0);
      check({tag, "_overrun"}, o_overrun, 0);
      check({tag, "_in_ready"}, o_in_ready, 0);
      check({tag, "_state"}, dbg_state, ST_IDLE);
   endtask

   initial begin
      reset      = 1'b1;
      i_in_valid = 1'b0;
      i_in_fmap  = '0;
      i_ot_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("rst");
      reset = 1'b0;
      #1;
      check("rel_ready", o_in_ready, 1);
      check("rel_valid", o_ot_valid, 0);
      @(negedge clk);

      // Full-rate frame, k+100.
      load_frame(0);
      send_frame();
      recv_frame(0, -1, -1);
      check("no_overrun", o_overrun, 0);

      // Stall at beat 7.
      load_frame(0);
      send_frame();
      recv_frame(1, -1, -1);

      // Random data, random ready.
      load_frame(3);
      send_frame();
      recv_frame(2, -1, -1);

      // Back-to-back: B pulsed on the first idle cycle.
      load_frame(1);
      send_frame();
      recv_frame(0, -1, -1);
      load_frame(2);
      send_frame();
      recv_frame(0, -1, -1);
      check("b2b_overrun", o_overrun, 0);

      // Second pulse while busy: sequence unchanged, overrun sticky.
      load_frame(0);
      send_frame();
      recv_frame(0, 9, -1);
      check("overrun_set", o_overrun, 1);
      repeat (3) @(negedge clk);
      check("overrun_sticky", o_overrun, 1);

      // Final-beat collision also counts as overrun; clear it with reset first.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("pre_collide_overrun", o_overrun, 0);
      load_frame(3);
      send_frame();
      recv_frame(0, N_PIX - 1, -1);
      check("collide_overrun", o_overrun, 1);

      // Reset mid-frame at beat 20.
      load_frame(3);
      send_frame();
      recv_frame(2, -1, 20);
      reset = 1'b1;
      #1;
      check_all_zero("mid_rst");
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("post_rst_ready", o_in_ready, 1);
      check("post_rst_valid", o_ot_valid, 0);
      check("post_rst_overrun", o_overrun, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_quiet", o_ot_valid, 0);
      end

      // Clean frame after reset.
      load_frame(3);
      send_frame();
      recv_frame(0, -1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
